// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack data-memory arbiter and its address decoder.
package hack_mem_pkg;

  localparam logic [14:0] RAM_LAST    = 15'd16383;
  localparam logic [14:0] SCREEN_BASE = 15'd16384;
  localparam logic [14:0] SCREEN_LAST = 15'd24575;
  localparam logic [14:0] KBD_ADDR    = 15'd24576;

  typedef enum logic [1:0] {RAM, SCREEN, KBD, INVALID} region_e;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

endpackage

// File: rtl/hack_mem_region_decode.sv
// Combinational Hack address classifier; also used by the CPU's address checks.
module hack_mem_region_decode
  import hack_mem_pkg::*;
(
  input  logic [14:0] i_addr,
  output region_e     o_region,
  output logic        o_write_ok
);

  always_comb begin
    o_region = INVALID;
    if (i_addr <= RAM_LAST)
      o_region = RAM;
    else if (i_addr <= SCREEN_LAST)
      o_region = SCREEN;
    else if (i_addr == KBD_ADDR)
      o_region = KBD;
  end

  assign o_write_ok = (o_region == RAM) || (o_region == SCREEN);

endmodule

// File: rtl/hack_mem_arbiter.sv
// Round-robin two-port arbiter in front of the Hack data memory.
// Optional grant hold across back-to-back accesses: define HACK_MEM_ARB_LOCK_EN.
//
// state  | meaning
// IDLE   | waiting for a request; arbitration happens here
// ACCESS | latched command drives the memory; writes commit at the end
// RESP   | ack/err/rdata presented to the winning port
module hack_mem_arbiter
  import hack_mem_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [14:0] p0_addr,
  input  logic [15:0] p0_wdata,
  input  logic        p0_lock,
  output logic        p0_ack,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [14:0] p1_addr,
  input  logic [15:0] p1_wdata,
  input  logic        p1_lock,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [15:0] rdata,
  output logic [15:0] mem_in,
  output logic [14:0] mem_address,
  output logic        mem_load,
  input  logic [15:0] mem_out,
  output logic        busy
);

  state_e      r_state;
  state_e      w_next;
  logic        r_last_grant;
  logic        r_winner;
  logic        r_we;
  logic [14:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_err;
  logic        w_pick;
  logic        w_sel;
  logic        w_latch;
  logic        w_lock_go;
  logic        w_reject;
  logic        w_write_ok;
  region_e     w_region;

  hack_mem_region_decode u_decode (
    .i_addr     (r_addr),
    .o_region   (w_region),
    .o_write_ok (w_write_ok)
  );

  assign w_reject = (w_region == INVALID) || (r_we && !w_write_ok);

  // On contention the port not granted last time wins; otherwise the lone requester.
  assign w_pick = (p0_req && p1_req) ? ~r_last_grant : ~p0_req;

`ifdef HACK_MEM_ARB_LOCK_EN
  assign w_lock_go = r_winner ? (p1_req && p1_lock) : (p0_req && p0_lock);
`else
  logic w_unused_lock;
  assign w_unused_lock = p0_lock | p1_lock;
  assign w_lock_go     = 1'b0;
`endif

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    w_sel   = r_winner;
    case (r_state)
      IDLE: begin
        if (p0_req || p1_req) begin
          w_next  = ACCESS;
          w_latch = 1'b1;
          w_sel   = w_pick;
        end
      end
      ACCESS: w_next = RESP;
      RESP: begin
        if (w_lock_go) begin
          w_next  = ACCESS;
          w_latch = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_winner     <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_winner <= w_sel;
        r_we     <= w_sel ? p1_we    : p0_we;
        r_addr   <= w_sel ? p1_addr  : p0_addr;
        r_wdata  <= w_sel ? p1_wdata : p0_wdata;
      end
      if (r_state == ACCESS) begin
        r_rdata <= w_reject ? 16'h0000 : mem_out;
        r_err   <= w_reject;
      end
      if (r_state == RESP)
        r_last_grant <= r_winner;
    end
  end

  // mem_load is decoded from the async-reset state so a reset kills it at once.
  assign mem_load    = (r_state == ACCESS) && r_we && w_write_ok;
  assign mem_address = r_addr;
  assign mem_in      = r_wdata;
  assign rdata       = r_rdata;
  assign busy        = (r_state != IDLE);
  assign p0_ack      = (r_state == RESP) && !r_winner;
  assign p1_ack      = (r_state == RESP) && r_winner;
  assign p0_err      = p0_ack && r_err;
  assign p1_err      = p1_ack && r_err;

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Directed bench for hack_mem_arbiter with a behavioural Hack memory model.
// The locked-sequence case is exercised only when HACK_MEM_ARB_LOCK_EN is defined.
module tb_hack_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
  logic [14:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [15:0] rdata, mem_in, mem_out;
  logic [14:0] mem_address;
  logic        mem_load, busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem_arr [0:24575];

  always #5 clock = ~clock;

  hack_mem_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_lock(p0_lock), .p0_ack(p0_ack), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock), .p1_ack(p1_ack), .p1_err(p1_err),
    .rdata(rdata), .mem_in(mem_in), .mem_address(mem_address),
    .mem_load(mem_load), .mem_out(mem_out), .busy(busy)
  );

  // RAM+screen array, fixed keyboard code, and a junk value above KBD.
  assign mem_out = (mem_address < 15'd24576) ? mem_arr[mem_address] :
                   (mem_address == 15'd24576) ? 16'h004B : 16'hBEEF;

  always @(posedge clock) begin
    if (!reset_n)
      mem_arr[256] <= 16'h1234;
    else if (mem_load && mem_address < 15'd24576)
      mem_arr[mem_address] <= mem_in;
  end

  typedef struct {
    logic        en;
    logic        we;
    logic [14:0] addr;
    logic [15:0] wd;
    logic        chk_rd;
    logic [15:0] rd;
    logic        err;
    int          lat;
  } txn_t;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [14:0] addr, input logic [15:0] wd,
                              input logic chk_rd, input logic [15:0] rd, input logic err,
                              input int lat);
    txn_t t;
    t.en = 1'b1; t.we = we; t.addr = addr; t.wd = wd;
    t.chk_rd = chk_rd; t.rd = rd; t.err = err; t.lat = lat;
    return t;
  endfunction

  function automatic txn_t no_txn();
    txn_t t;
    t.en = 1'b0; t.we = 1'b0; t.addr = '0; t.wd = '0;
    t.chk_rd = 1'b0; t.rd = '0; t.err = 1'b0; t.lat = 0;
    return t;
  endfunction

  // Issues up to one request per port on the same cycle and tracks both acks;
  // latency counts negedges after the request was driven.
  task automatic run_txn(input string tag, input txn_t t0, input txn_t t1, input int exp_loads);
    logic [14:0] ahist [0:15];
    logic [15:0] dhist [0:15];
    int  lat0 = 0;
    int  lat1 = 0;
    int  loads = 0;
    int  cyc = 0;
    bit  d0, d1;
    @(negedge clock);
    check_val({tag, " idle busy"}, 32'(busy), 0);
    p0_req = t0.en; p0_we = t0.we; p0_addr = t0.addr; p0_wdata = t0.wd;
    p1_req = t1.en; p1_we = t1.we; p1_addr = t1.addr; p1_wdata = t1.wd;
    d0 = !t0.en;
    d1 = !t1.en;
    while (!(d0 && d1) && cyc < 14) begin
      @(negedge clock);
      cyc++;
      ahist[cyc] = mem_address;
      dhist[cyc] = mem_in;
      if (mem_load) loads++;
      if (p0_ack) begin
        if (d0) check_val({tag, " p0 stray ack"}, 1, 0);
        else begin
          lat0 = cyc;
          check_val({tag, " p0 err"}, 32'(p0_err), 32'(t0.err));
          if (t0.chk_rd) check_val({tag, " p0 rdata"}, 32'(rdata), 32'(t0.rd));
        end
        d0 = 1'b1;
        p0_req = 1'b0;
      end
      if (p1_ack) begin
        if (d1) check_val({tag, " p1 stray ack"}, 1, 0);
        else begin
          lat1 = cyc;
          check_val({tag, " p1 err"}, 32'(p1_err), 32'(t1.err));
          if (t1.chk_rd) check_val({tag, " p1 rdata"}, 32'(rdata), 32'(t1.rd));
        end
        d1 = 1'b1;
        p1_req = 1'b0;
      end
    end
    if (!(d0 && d1)) check_val({tag, " timeout"}, 32'({d1, d0}), 3);
    p0_req = 1'b0;
    p1_req = 1'b0;
    if (t0.en) begin
      check_val({tag, " p0 latency"}, 32'(lat0), 32'(t0.lat));
      if (lat0 > 0) check_val({tag, " p0 mem_address"}, 32'(ahist[lat0-1]), 32'(t0.addr));
      if (lat0 > 0 && t0.we) check_val({tag, " p0 mem_in"}, 32'(dhist[lat0-1]), 32'(t0.wd));
    end
    if (t1.en) begin
      check_val({tag, " p1 latency"}, 32'(lat1), 32'(t1.lat));
      if (lat1 > 0) check_val({tag, " p1 mem_address"}, 32'(ahist[lat1-1]), 32'(t1.addr));
      if (lat1 > 0 && t1.we) check_val({tag, " p1 mem_in"}, 32'(dhist[lat1-1]), 32'(t1.wd));
    end
    check_val({tag, " load cycles"}, 32'(loads), 32'(exp_loads));
  endtask

`ifdef HACK_MEM_ARB_LOCK_EN
  task automatic run_lock();
    int k = 0;
    int p1_at = 0;
    int cyc = 0;
    int at [3];
    at[0] = 0; at[1] = 0; at[2] = 0;
    @(negedge clock);
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 15'd500; p0_wdata = 16'h5001; p0_lock = 1'b1;
    while ((k < 3 || p1_at == 0) && cyc < 20) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 15'd500; p1_wdata = 16'h0000;
      end
      if (k == 2 && cyc == at[1] + 1) p0_lock = 1'b0;
      if (p0_ack && k < 3) begin
        at[k] = cyc;
        k++;
        if (k == 1) begin p0_addr = 15'd501; p0_wdata = 16'h5002; end
        else if (k == 2) begin p0_addr = 15'd502; p0_wdata = 16'h5003; end
        else p0_req = 1'b0;
      end
      if (p1_ack && p1_at == 0) begin
        p1_at = cyc;
        check_val("lock p1 rdata", 32'(rdata), 32'h5001);
        p1_req = 1'b0;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0; p0_lock = 1'b0;
    check_val("lock p0 ack1", 32'(at[0]), 2);
    check_val("lock p0 ack2", 32'(at[1]), 4);
    check_val("lock p0 ack3", 32'(at[2]), 6);
    check_val("lock p1 ack", 32'(p1_at), 9);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_lock = 1'b0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_lock = 1'b0;
    repeat (3) @(negedge clock);
    check_val("rst p0_ack", 32'(p0_ack), 0);
    check_val("rst p1_ack", 32'(p1_ack), 0);
    check_val("rst p0_err", 32'(p0_err), 0);
    check_val("rst p1_err", 32'(p1_err), 0);
    check_val("rst rdata", 32'(rdata), 0);
    check_val("rst mem_load", 32'(mem_load), 0);
    check_val("rst mem_address", 32'(mem_address), 0);
    check_val("rst mem_in", 32'(mem_in), 0);
    check_val("rst busy", 32'(busy), 0);
    reset_n = 1'b1;

    run_txn("contend1", mk(1'b0, 15'd256, 16'h0, 1'b1, 16'h1234, 1'b0, 2),
                        mk(1'b1, 15'd24575, 16'd7, 1'b0, 16'h0, 1'b0, 5), 1);
    run_txn("rd24575", no_txn(), mk(1'b0, 15'd24575, 16'h0, 1'b1, 16'd7, 1'b0, 2), 0);
    run_txn("wr16384", mk(1'b1, 15'd16384, 16'd64, 1'b0, 16'h0, 1'b0, 2), no_txn(), 1);
    run_txn("rd16384", mk(1'b0, 15'd16384, 16'h0, 1'b1, 16'd64, 1'b0, 2), no_txn(), 0);
    run_txn("wr kbd", no_txn(), mk(1'b1, 15'd24576, 16'h1111, 1'b1, 16'h0, 1'b1, 2), 0);
    run_txn("rd kbd", no_txn(), mk(1'b0, 15'd24576, 16'h0, 1'b1, 16'h004B, 1'b0, 2), 0);
    run_txn("rd inval", mk(1'b0, 15'd24577, 16'h0, 1'b1, 16'h0, 1'b1, 2), no_txn(), 0);
    run_txn("wr inval", mk(1'b1, 15'd30000, 16'h2222, 1'b1, 16'h0, 1'b1, 2), no_txn(), 0);
    run_txn("contend2", mk(1'b0, 15'd16384, 16'h0, 1'b1, 16'd64, 1'b0, 5),
                        mk(1'b1, 15'd0, 16'h00AA, 1'b0, 16'h0, 1'b0, 2), 1);
    run_txn("rd0", mk(1'b0, 15'd0, 16'h0, 1'b1, 16'h00AA, 1'b0, 2), no_txn(), 0);

    run_txn("pre300", mk(1'b1, 15'd300, 16'h0111, 1'b0, 16'h0, 1'b0, 2), no_txn(), 1);
    @(negedge clock);
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 15'd300; p0_wdata = 16'hDEAD;
    @(negedge clock);
    check_val("abort load before", 32'(mem_load), 1);
    #1 reset_n = 1'b0;
    #1;
    check_val("abort load after", 32'(mem_load), 0);
    check_val("abort busy", 32'(busy), 0);
    check_val("abort mem_address", 32'(mem_address), 0);
    #1 reset_n = 1'b1;
    p0_req = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check_val("abort no ack", 32'({p1_ack, p0_ack}), 0);
    end
    run_txn("rd300", mk(1'b0, 15'd300, 16'h0, 1'b1, 16'h0111, 1'b0, 2), no_txn(), 0);

`ifdef HACK_MEM_ARB_LOCK_EN
    run_lock();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
